// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: accepts one AC snoop, looks the line up in the cache,
// applies the coherence update, answers on CR and streams the line on CD.
package ace_snoop_pkg;
    localparam int AddrW = 32;
    localparam int DataW = 64;

    typedef struct packed {
        logic [AddrW-1:0] addr;
        logic [3:0]       snoop;
    } ac_chan_t;

    typedef struct packed {
        logic     ac_valid;
        ac_chan_t ac;
        logic     cr_ready;
        logic     cd_ready;
    } snoop_req_t;

    typedef struct packed {
        logic [DataW-1:0] data;
        logic             last;
    } cd_chan_t;

    typedef struct packed {
        logic     ac_ready;
        logic     cr_valid;
        logic [4:0] cr_resp;
        logic     cd_valid;
        cd_chan_t cd;
    } snoop_resp_t;
endpackage

module ace_snoop_responder #(
    parameter int  DcacheLineWidth = 512,
    parameter int  AxiDataWidth    = ace_snoop_pkg::DataW,
    parameter int  AxiAddrWidth    = ace_snoop_pkg::AddrW,
    parameter type snoop_req_t     = ace_snoop_pkg::snoop_req_t,
    parameter type snoop_resp_t    = ace_snoop_pkg::snoop_resp_t
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  snoop_req_t                 snoop_req_i,
    output snoop_resp_t                snoop_resp_o,
    output logic                       lookup_valid_o,
    input  logic                       lookup_ready_i,
    output logic [AxiAddrWidth-1:0]    lookup_addr_o,
    input  logic                       lookup_rsp_valid_i,
    input  logic                       lookup_hit_i,
    input  logic                       lookup_dirty_i,
    input  logic                       lookup_unique_i,
    input  logic [DcacheLineWidth-1:0] lookup_data_i,
    output logic                       upd_valid_o,
    input  logic                       upd_ready_i,
    output logic [AxiAddrWidth-1:0]    upd_addr_o,
    output logic                       upd_invalidate_o,
    output logic                       upd_clear_dirty_o,
    output logic                       upd_clear_unique_o
);
    // state  | meaning
    // IDLE   | ready for a new AC snoop
    // LOOKUP | presenting the line address to the cache
    // WAIT   | waiting for the lookup result
    // UPD    | presenting the coherence state update
    // CR     | presenting the snoop response
    // CD     | streaming line data beats
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_UPD    = 3'd3;
    localparam logic [2:0] S_CR     = 3'd4;
    localparam logic [2:0] S_CD     = 3'd5;

    localparam int NumBeats = DcacheLineWidth / AxiDataWidth;
    localparam int BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;
    localparam int OffW     = $clog2(DcacheLineWidth / 8);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(NumBeats - 1);

    logic [2:0]                 state_q;
    logic [AxiAddrWidth-1:0]    addr_q;
    logic [3:0]                 snoop_q;
    logic [DcacheLineWidth-1:0] data_q;
    logic [4:0]                 cr_resp_q;
    logic                       inv_q, clr_dirty_q, clr_unique_q;
    logic [BeatW-1:0]           beat_q;

    logic dec_dt, dec_pd, dec_is, dec_inv, dec_cd, dec_cu;
    logic snoop_known;

    always_comb begin
        unique case (snoop_req_i.ac.snoop)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0111, 4'b1000, 4'b1001, 4'b1101: snoop_known = 1'b1;
            default:                            snoop_known = 1'b0;
        endcase
    end

    always_comb begin
        dec_dt  = 1'b0;
        dec_pd  = 1'b0;
        dec_is  = 1'b0;
        dec_inv = 1'b0;
        dec_cd  = 1'b0;
        dec_cu  = 1'b0;
        case (snoop_q)
            4'b0000: begin dec_dt = 1'b1; dec_is = 1'b1; end
            4'b0001: begin
                dec_dt = 1'b1; dec_is = 1'b1; dec_pd = lookup_dirty_i;
                dec_cd = 1'b1; dec_cu = 1'b1;
            end
            4'b0010, 4'b0011: begin dec_dt = 1'b1; dec_is = 1'b1; dec_cu = 1'b1; end
            4'b0111: begin dec_dt = 1'b1; dec_pd = lookup_dirty_i; dec_inv = 1'b1; end
            4'b1000: begin
                dec_dt = lookup_dirty_i; dec_pd = lookup_dirty_i; dec_is = 1'b1;
                dec_cd = lookup_dirty_i;
            end
            4'b1001: begin dec_dt = lookup_dirty_i; dec_pd = lookup_dirty_i; dec_inv = 1'b1; end
            4'b1101: dec_inv = 1'b1;
            default: ;
        endcase
        // A miss answers with an all-zero response and leaves the cache alone.
        if (!lookup_hit_i) begin
            dec_dt  = 1'b0;
            dec_pd  = 1'b0;
            dec_is  = 1'b0;
            dec_inv = 1'b0;
            dec_cd  = 1'b0;
            dec_cu  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            snoop_q      <= '0;
            data_q       <= '0;
            cr_resp_q    <= '0;
            inv_q        <= 1'b0;
            clr_dirty_q  <= 1'b0;
            clr_unique_q <= 1'b0;
            beat_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (snoop_req_i.ac_valid) begin
                    addr_q       <= snoop_req_i.ac.addr;
                    snoop_q      <= snoop_req_i.ac.snoop;
                    cr_resp_q    <= '0;
                    inv_q        <= 1'b0;
                    clr_dirty_q  <= 1'b0;
                    clr_unique_q <= 1'b0;
                    beat_q       <= '0;
                    state_q      <= snoop_known ? S_LOOKUP : S_CR;
                end
                S_LOOKUP: if (lookup_ready_i) state_q <= S_WAIT;
                S_WAIT: if (lookup_rsp_valid_i) begin
                    data_q       <= lookup_data_i;
                    cr_resp_q    <= {lookup_hit_i & lookup_unique_i, dec_is, dec_pd, 1'b0, dec_dt};
                    inv_q        <= dec_inv;
                    clr_dirty_q  <= dec_cd;
                    clr_unique_q <= dec_cu;
                    state_q      <= (dec_inv | dec_cd | dec_cu) ? S_UPD : S_CR;
                end
                S_UPD: if (upd_ready_i) state_q <= S_CR;
                S_CR: if (snoop_req_i.cr_ready) state_q <= cr_resp_q[0] ? S_CD : S_IDLE;
                S_CD: if (snoop_req_i.cd_ready) begin
                    if (beat_q == LastBeat) begin
                        beat_q  <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        snoop_resp_o          = '0;
        snoop_resp_o.ac_ready = (state_q == S_IDLE) && !rst_i;
        snoop_resp_o.cr_valid = (state_q == S_CR);
        snoop_resp_o.cr_resp  = (state_q == S_CR) ? cr_resp_q : 5'b0;
        snoop_resp_o.cd_valid = (state_q == S_CD);
        if (state_q == S_CD) begin
            snoop_resp_o.cd.data = data_q[int'(beat_q)*AxiDataWidth +: AxiDataWidth];
            snoop_resp_o.cd.last = (beat_q == LastBeat);
        end
    end

    assign lookup_valid_o     = (state_q == S_LOOKUP);
    assign lookup_addr_o      = {addr_q[AxiAddrWidth-1:OffW], {OffW{1'b0}}};
    assign upd_valid_o        = (state_q == S_UPD);
    assign upd_addr_o         = {addr_q[AxiAddrWidth-1:OffW], {OffW{1'b0}}};
    assign upd_invalidate_o   = upd_valid_o & inv_q;
    assign upd_clear_dirty_o  = upd_valid_o & clr_dirty_q;
    assign upd_clear_unique_o = upd_valid_o & clr_unique_q;
endmodule

// File: tb/tb_ace_snoop_responder.sv
// Bench for ace_snoop_responder: vector table plus hand sequences for
// backpressure, DVM and reset mid-burst; CR/CD results go through a scoreboard.
module tb_ace_snoop_responder;
    import ace_snoop_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i;
    snoop_req_t   req;
    snoop_resp_t  resp;
    logic         lookup_valid_o, lookup_ready_i, lookup_rsp_valid_i;
    logic [31:0]  lookup_addr_o, upd_addr_o;
    logic         lookup_hit_i, lookup_dirty_i, lookup_unique_i;
    logic [511:0] lookup_data_i;
    logic         upd_valid_o, upd_ready_i;
    logic         upd_invalidate_o, upd_clear_dirty_o, upd_clear_unique_o;

    ace_snoop_responder dut (
        .clk_i(clk_i), .rst_i(rst_i), .snoop_req_i(req), .snoop_resp_o(resp),
        .lookup_valid_o(lookup_valid_o), .lookup_ready_i(lookup_ready_i),
        .lookup_addr_o(lookup_addr_o), .lookup_rsp_valid_i(lookup_rsp_valid_i),
        .lookup_hit_i(lookup_hit_i), .lookup_dirty_i(lookup_dirty_i),
        .lookup_unique_i(lookup_unique_i), .lookup_data_i(lookup_data_i),
        .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i), .upd_addr_o(upd_addr_o),
        .upd_invalidate_o(upd_invalidate_o), .upd_clear_dirty_o(upd_clear_dirty_o),
        .upd_clear_unique_o(upd_clear_unique_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  snoop;
        logic [31:0] addr;
        logic        hit, dirty, uniq;
        logic [4:0]  cr;
        bit          lk, uv, inv, cd, cu;
    } vec_t;

    typedef struct { logic [4:0] cr; bit uv; } exp_t;
    typedef struct { logic [63:0] data; logic last; } beat_t;

    exp_t  exp_q[$];
    beat_t beat_q[$];
    int    tests = 0;
    int    fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", nm, act, want);
        end
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic run(input vec_t v, input logic [511:0] line, input int cr_stall,
                       input bit cd_toggle, input int rst_beat);
        exp_t  e;
        beat_t b;
        int    n, lookups, upd_seen, n_cr, n_crh, n_cd, stall, beats_done;
        bit    done, rsp_next, rdy;
        n = 0; lookups = 0; upd_seen = 0; n_cr = -1; n_crh = -1; n_cd = -1;
        stall = 0; beats_done = 0; done = 0; rsp_next = 0;

        @(negedge clk_i);
        chk("ac_ready_idle", resp.ac_ready, 1);
        req.ac_valid = 1'b1;
        req.ac.addr  = v.addr;
        req.ac.snoop = v.snoop;
        e.cr = v.cr;
        e.uv = v.uv;
        exp_q.push_back(e);
        if (v.cr[0])
            for (int i = 0; i < 8; i++) begin
                b.data = line[i*64 +: 64];
                b.last = (i == 7);
                beat_q.push_back(b);
            end

        while (!done && n < 100) begin
            @(negedge clk_i);
            n++;
            req.ac_valid       = 1'b0;
            lookup_rsp_valid_i = 1'b0;
            lookup_hit_i       = 1'b0;
            lookup_dirty_i     = 1'b0;
            lookup_unique_i    = 1'b0;
            lookup_data_i      = '0;
            if (resp.ac_ready) begin
                done = 1;
                req.cr_ready = 1'b0;
                req.cd_ready = 1'b0;
            end else begin
                if (rsp_next) begin
                    lookup_rsp_valid_i = 1'b1;
                    lookup_hit_i       = v.hit;
                    lookup_dirty_i     = v.dirty;
                    lookup_unique_i    = v.uniq;
                    lookup_data_i      = line;
                    rsp_next = 0;
                end else if (n == 1) begin
                    // stray pulse outside WAIT: must not be captured
                    lookup_rsp_valid_i = 1'b1;
                    lookup_hit_i       = 1'b1;
                    lookup_dirty_i     = 1'b1;
                    lookup_unique_i    = 1'b1;
                    lookup_data_i      = ~line;
                end
                if (lookup_valid_o) begin
                    lookups++;
                    if (lookups == 1) chk("lookup_addr", lookup_addr_o, {v.addr[31:6], 6'b0});
                    if (lookup_ready_i) rsp_next = 1;
                end
                if (upd_valid_o) begin
                    upd_seen++;
                    if (upd_seen == 1) begin
                        chk("upd_flags", {upd_invalidate_o, upd_clear_dirty_o, upd_clear_unique_o},
                            {v.inv, v.cd, v.cu});
                        chk("upd_addr", upd_addr_o, {v.addr[31:6], 6'b0});
                    end
                end
                if (resp.cr_valid) begin
                    if (n_cr < 0) n_cr = n;
                    if (stall < cr_stall) begin
                        stall++;
                        req.cr_ready = 1'b0;
                        chk("cr_resp_held", resp.cr_resp, v.cr);
                    end else begin
                        req.cr_ready = 1'b1;
                        n_crh = n;
                        if (exp_q.size() == 0) begin
                            chk("cr_unexpected", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("cr_resp", resp.cr_resp, e.cr);
                            chk("upd_before_cr", upd_seen > 0, e.uv);
                        end
                    end
                end else begin
                    req.cr_ready = 1'b0;
                end
                if (resp.cd_valid) begin
                    if (rst_beat >= 0 && beats_done == rst_beat) begin
                        rst_i = 1'b1;
                        #1;
                        chk("rst_cd_valid", resp.cd_valid, 0);
                        chk("rst_ac_ready", resp.ac_ready, 0);
                        beat_q.delete();
                        exp_q.delete();
                        req.cd_ready = 1'b0;
                        @(negedge clk_i);
                        rst_i = 1'b0;
                        #1;
                        chk("post_rst_ac_ready", resp.ac_ready, 1);
                        return;
                    end
                    if (n_cd < 0) begin
                        n_cd = n;
                        chk("cd_after_cr", n_cd, n_crh + 1);
                    end
                    rdy = cd_toggle ? ((n % 2) == 1) : 1'b1;
                    req.cd_ready = rdy;
                    if (rdy) begin
                        if (beat_q.size() == 0) begin
                            chk("cd_unexpected", 1, 0);
                        end else begin
                            b = beat_q.pop_front();
                            chk("cd_data", resp.cd.data, b.data);
                            chk("cd_last", resp.cd.last, b.last);
                        end
                        beats_done++;
                    end
                end else begin
                    req.cd_ready = 1'b0;
                end
            end
        end
        if (!done) chk("timeout", n, 0);
        chk("lookup_issued", lookups > 0, v.lk);
        chk("upd_issued", upd_seen > 0, v.uv);
        chk("cr_latency", n_cr, v.lk ? (v.uv ? 4 : 3) : 1);
        chk("beats_left", beat_q.size(), 0);
        chk("cr_left", exp_q.size(), 0);
        exp_q.delete();
        beat_q.delete();
    endtask

    vec_t vt[13];
    vec_t hv;

    initial begin
        //        snoop    addr          hit dty unq cr         lk uv inv cd cu
        vt[0]  = '{4'b0001, 32'h0000_1040, 0, 0, 0, 5'b00000, 1, 0, 0, 0, 0};
        vt[1]  = '{4'b0111, 32'h0000_2078, 1, 1, 1, 5'b10101, 1, 1, 1, 0, 0};
        vt[2]  = '{4'b1000, 32'h0000_3000, 1, 0, 0, 5'b01000, 1, 0, 0, 0, 0};
        vt[3]  = '{4'b0000, 32'h0000_4010, 1, 1, 1, 5'b11001, 1, 0, 0, 0, 0};
        vt[4]  = '{4'b0010, 32'h0000_5080, 1, 1, 1, 5'b11001, 1, 1, 0, 0, 1};
        vt[5]  = '{4'b0011, 32'h0000_60C4, 1, 0, 0, 5'b01001, 1, 1, 0, 0, 1};
        vt[6]  = '{4'b0001, 32'h0000_7100, 1, 0, 1, 5'b11001, 1, 1, 0, 1, 1};
        vt[7]  = '{4'b1000, 32'h0000_8140, 1, 1, 1, 5'b11101, 1, 1, 0, 1, 0};
        vt[8]  = '{4'b1001, 32'h0000_9180, 1, 1, 0, 5'b00101, 1, 1, 1, 0, 0};
        vt[9]  = '{4'b1001, 32'h0000_A1C0, 1, 0, 0, 5'b00000, 1, 1, 1, 0, 0};
        vt[10] = '{4'b1101, 32'h0000_B200, 1, 1, 1, 5'b10000, 1, 1, 1, 0, 0};
        vt[11] = '{4'b1111, 32'h0000_C240, 1, 1, 1, 5'b00000, 0, 0, 0, 0, 0};
        vt[12] = '{4'b0111, 32'h0000_D280, 0, 1, 1, 5'b00000, 1, 0, 0, 0, 0};

        rst_i = 1'b1;
        req = '0;
        lookup_ready_i = 1'b1;
        upd_ready_i = 1'b1;
        lookup_rsp_valid_i = 1'b0;
        lookup_hit_i = 1'b0;
        lookup_dirty_i = 1'b0;
        lookup_unique_i = 1'b0;
        lookup_data_i = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_ac_ready", resp.ac_ready, 0);
        chk("rst_valids", {lookup_valid_o, upd_valid_o, resp.cr_valid, resp.cd_valid}, 0);
        chk("rst_resp", resp, 0);
        rst_i = 1'b0;
        #1;
        chk("rel_ac_ready", resp.ac_ready, 1);

        for (int i = 0; i < 13; i++) run(vt[i], rand_line(), 0, 0, -1);

        // ReadShared dirty hit under CR and CD backpressure, then DVM
        hv = '{4'b0001, 32'h0000_E000, 1, 1, 0, 5'b01101, 1, 1, 0, 1, 1};
        run(hv, rand_line(), 3, 1, -1);
        run(vt[11], rand_line(), 0, 0, -1);

        // reset during the third CD beat, then a clean follow-up snoop
        run(vt[1], rand_line(), 0, 0, 2);
        run(vt[7], rand_line(), 0, 1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
